// File: rtl/uart_pkg.sv
// UART register bank shared definitions: register word indices, interrupt
// bit positions, CTRL field layout.
package uart_pkg;

  // Register word indices
  localparam logic [3:0] DATA_REG     = 4'd0;
  localparam logic [3:0] STATUS_REG   = 4'd1;
  localparam logic [3:0] CTRL_REG     = 4'd2;
  localparam logic [3:0] BAUD_REG     = 4'd3;
  localparam logic [3:0] INT_EN_REG   = 4'd4;
  localparam logic [3:0] INT_STAT_REG = 4'd5;
  localparam logic [3:0] WMARK_REG    = 4'd6;
  localparam logic [3:0] LEVEL_REG    = 4'd7;
  localparam logic [3:0] TIMEOUT_REG  = 4'd8;

  // INT_STAT / INT_EN bit positions
  typedef enum logic [2:0] {
    INT_RX_WM    = 3'd0,
    INT_TX_WM    = 3'd1,
    INT_PAR_ERR  = 3'd2,
    INT_STOP_ERR = 3'd3,
    INT_RX_OVR   = 3'd4,
    INT_TX_OVF   = 3'd5,
    INT_RX_UDF   = 3'd6,
    INT_RX_TMO   = 3'd7
  } int_bit_e;

  // Bits 2..7 are the sticky (W1C) part of INT_STAT
  localparam int STICKY_LO = 2;
  localparam int STICKY_W  = 6;

  // CTRL field positions
  localparam int CTRL_UART_EN = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_PARITY  = 2;
  localparam int CTRL_PAR_EN  = 3;
  localparam int CTRL_TX_EN   = 4;
  localparam int CTRL_RX_EN   = 5;

  typedef struct packed {
    logic rx_en;
    logic tx_en;
    logic parity_enable;
    logic parity;
    logic stop_bit;
    logic uart_en;
  } ctrl_t;

endpackage

// File: rtl/uart_sticky_flags.sv
// Vector of sticky flags: set pulses latch a bit, write-1-to-clear drops it;
// a set in the same cycle as a clear wins. Also exposes the next-state so
// consumers can react in the same cycle the flag is being latched.
module uart_sticky_flags #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] i_set,
  input  logic [W-1:0] i_clr,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_nxt
);

  logic [W-1:0] r_q;

  assign o_nxt = (r_q & ~i_clr) | i_set;
  assign o_q   = r_q;

  // Flag register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_q <= '0;
    else          r_q <= o_nxt;
  end

endmodule

// File: rtl/uart_csr_bank.sv
// UART register bank between the load/store path and the UART core.
// Optional receive idle-timeout register/counter: define UART_RX_TIMEOUT_EN.
module uart_csr_bank
  import uart_pkg::*;
#(
  parameter int              DATA_BITS  = 8,
  parameter int              BAUD_W     = 16,
  parameter int              FIFO_DEPTH = 16,
  parameter int              LEVEL_W    = $clog2(FIFO_DEPTH) + 1,
  parameter logic [BAUD_W-1:0] BAUD_RESET = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 bus_sel,
  input  logic                 bus_wr,
  input  logic                 bus_rd,
  input  logic [3:0]           bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 irq,
  input  logic                 tx_fifo_full,
  input  logic                 rx_fifo_full,
  input  logic                 rx_fifo_empty,
  input  logic                 busy,
  input  logic [LEVEL_W-1:0]   tx_level,
  input  logic [LEVEL_W-1:0]   rx_level,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_push,
  input  logic                 parity_err_p,
  input  logic                 stop_err_p,
  output logic                 tx_fifo_wr_en,
  output logic [DATA_BITS-1:0] tx_fifo_data,
  output logic                 rx_fifo_rd_en,
  output logic                 uart_en,
  output logic                 stop_bit,
  output logic                 parity,
  output logic                 parity_enable,
  output logic                 tx_en,
  output logic                 rx_en,
  output logic [BAUD_W-1:0]    baud_rate
);

  logic w_wr, w_rd, w_data_wr, w_data_rd, w_push, w_pop;
  logic w_rx_wm_hit, w_tx_wm_hit, w_tmo_set;
  logic [7:0]          w_ev;
  logic [STICKY_W-1:0] w_clr, w_sticky, w_sticky_nxt;
  logic [7:0]          w_stat, w_stat_nxt;
  logic [31:0]         w_timeout_rd;
  logic                w_unused;

  ctrl_t                r_ctrl;
  logic [BAUD_W-1:0]    r_baud;
  logic [7:0]           r_int_en, r_rx_wm, r_tx_wm;
  logic                 r_tx_wr_en;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_irq;

  assign w_wr      = bus_sel & bus_wr;
  assign w_rd      = bus_sel & bus_rd;
  assign w_data_wr = w_wr && (bus_addr == DATA_REG);
  assign w_data_rd = w_rd && (bus_addr == DATA_REG);
  assign w_push    = w_data_wr & ~tx_fifo_full;
  // Pop is combinational with the read; reset kills it immediately
  assign w_pop     = w_data_rd & ~rx_fifo_empty & reset_n;

  // Upper write-data bits and the level-only event slots have no storage
  assign w_unused = ^{bus_wdata, w_ev[1:0]};

  // TX push strobe: one cycle after the accepted DATA write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wr_en <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_wr_en <= w_push;
      if (w_push) r_tx_data <= bus_wdata[DATA_BITS-1:0];
    end
  end

  // Configuration registers; frame format and divisor are frozen while the
  // core is shifting so a character is never sent with mixed settings
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl   <= '0;
      r_baud   <= BAUD_RESET;
      r_int_en <= '0;
      r_rx_wm  <= 8'd1;
      r_tx_wm  <= 8'd0;
    end else begin
      if (w_wr && bus_addr == CTRL_REG) begin
        r_ctrl.uart_en <= bus_wdata[CTRL_UART_EN];
        r_ctrl.tx_en   <= bus_wdata[CTRL_TX_EN];
        r_ctrl.rx_en   <= bus_wdata[CTRL_RX_EN];
        if (!busy) begin
          r_ctrl.stop_bit      <= bus_wdata[CTRL_STOP];
          r_ctrl.parity        <= bus_wdata[CTRL_PARITY];
          r_ctrl.parity_enable <= bus_wdata[CTRL_PAR_EN];
        end
      end
      if (w_wr && bus_addr == BAUD_REG && !(busy || r_ctrl.uart_en))
        r_baud <= bus_wdata[BAUD_W-1:0];
      if (w_wr && bus_addr == INT_EN_REG)
        r_int_en <= bus_wdata[7:0];
      if (w_wr && bus_addr == WMARK_REG) begin
        r_rx_wm <= bus_wdata[7:0];
        r_tx_wm <= bus_wdata[15:8];
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [15:0] r_timeout, r_idle;
  logic        w_tmo_hit;

  assign w_tmo_hit    = (r_timeout != '0) && (r_idle == r_timeout);
  assign w_tmo_set    = w_tmo_hit;
  assign w_timeout_rd = {16'b0, r_timeout};

  // Timeout threshold register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               r_timeout <= '0;
    else if (w_wr && bus_addr == TIMEOUT_REG)   r_timeout <= bus_wdata[15:0];
  end

  // Idle counter: restarts on any rx activity or empty FIFO, parks at threshold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                   r_idle <= '0;
    else if (rx_push || w_pop || rx_fifo_empty)     r_idle <= '0;
    else if (!w_tmo_hit && r_ctrl.uart_en && r_ctrl.rx_en) r_idle <= r_idle + 16'd1;
  end
`else
  assign w_tmo_set    = 1'b0;
  assign w_timeout_rd = '0;
`endif

  // Interrupt event sources by INT_STAT position
  always_comb begin
    w_ev               = '0;
    w_ev[INT_PAR_ERR]  = parity_err_p;
    w_ev[INT_STOP_ERR] = stop_err_p;
    w_ev[INT_RX_OVR]   = rx_push & rx_fifo_full;
    w_ev[INT_TX_OVF]   = w_data_wr & tx_fifo_full;
    w_ev[INT_RX_UDF]   = w_data_rd & rx_fifo_empty;
    w_ev[INT_RX_TMO]   = w_tmo_set;
  end

  assign w_clr = (w_wr && bus_addr == INT_STAT_REG) ? bus_wdata[7:STICKY_LO] : '0;

  uart_sticky_flags #(.W(STICKY_W)) u_sticky (
    .clock   (clock),
    .reset_n (reset_n),
    .i_set   (w_ev[7:STICKY_LO]),
    .i_clr   (w_clr),
    .o_q     (w_sticky),
    .o_nxt   (w_sticky_nxt)
  );

  assign w_rx_wm_hit = rx_level >= r_rx_wm[LEVEL_W-1:0];
  assign w_tx_wm_hit = tx_level <= r_tx_wm[LEVEL_W-1:0];
  assign w_stat      = {w_sticky,     w_tx_wm_hit, w_rx_wm_hit};
  assign w_stat_nxt  = {w_sticky_nxt, w_tx_wm_hit, w_rx_wm_hit};

  // irq follows the flag next-state so it rises the cycle after the event
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= r_ctrl.uart_en & |(w_stat_nxt & r_int_en);
  end

  // Read mux, combinational from the address
  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      DATA_REG:     bus_rdata = rx_fifo_empty ? 32'd0 : 32'(rx_data);
      STATUS_REG:   bus_rdata = {24'b0, r_tx_wr_en, w_pop, rx_fifo_full, tx_fifo_full,
                                 rx_fifo_empty, w_sticky[0], w_sticky[1], busy};
      CTRL_REG:     bus_rdata = {26'b0, r_ctrl};
      BAUD_REG:     bus_rdata = 32'(r_baud);
      INT_EN_REG:   bus_rdata = {24'b0, r_int_en};
      INT_STAT_REG: bus_rdata = {24'b0, w_stat};
      WMARK_REG:    bus_rdata = {16'b0, r_tx_wm, r_rx_wm};
      LEVEL_REG:    bus_rdata = (32'(rx_level) << 16) | 32'(tx_level);
      TIMEOUT_REG:  bus_rdata = w_timeout_rd;
      default:      bus_rdata = '0;
    endcase
  end

  assign rx_fifo_rd_en = w_pop;
  assign tx_fifo_wr_en = r_tx_wr_en;
  assign tx_fifo_data  = r_tx_data;
  assign irq           = r_irq;
  assign uart_en       = r_ctrl.uart_en;
  assign stop_bit      = r_ctrl.stop_bit;
  assign parity        = r_ctrl.parity;
  assign parity_enable = r_ctrl.parity_enable;
  assign tx_en         = r_ctrl.tx_en;
  assign rx_en         = r_ctrl.rx_en;
  assign baud_rate     = r_baud;

endmodule

// File: tb/tb_uart_csr_bank.sv
// Self-checking bench for uart_csr_bank (default build, 8-bit chars, depth 16).
module tb_uart_csr_bank;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        bus_sel = 0, bus_wr = 0, bus_rd = 0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic        irq;
  logic        tx_fifo_full = 0, rx_fifo_full = 0, rx_fifo_empty = 0, busy = 0;
  logic [4:0]  tx_level = 5'd3, rx_level = 5'd0;
  logic [7:0]  rx_data = '0;
  logic        rx_push = 0, parity_err_p = 0, stop_err_p = 0;
  logic        tx_fifo_wr_en, rx_fifo_rd_en;
  logic [7:0]  tx_fifo_data;
  logic        uart_en, stop_bit, parity, parity_enable, tx_en, rx_en;
  logic [15:0] baud_rate;

  int n_vec = 0, n_err = 0;

  uart_csr_bank dut (
    .clock(clock), .reset_n(reset_n), .bus_sel(bus_sel), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
    .tx_fifo_full(tx_fifo_full), .rx_fifo_full(rx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
    .busy(busy), .tx_level(tx_level), .rx_level(rx_level), .rx_data(rx_data), .rx_push(rx_push),
    .parity_err_p(parity_err_p), .stop_err_p(stop_err_p), .tx_fifo_wr_en(tx_fifo_wr_en),
    .tx_fifo_data(tx_fifo_data), .rx_fifo_rd_en(rx_fifo_rd_en), .uart_en(uart_en),
    .stop_bit(stop_bit), .parity(parity), .parity_enable(parity_enable), .tx_en(tx_en),
    .rx_en(rx_en), .baud_rate(baud_rate)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [5:0]  m_ctrl;
  logic [15:0] m_baud;
  logic [7:0]  m_inten, m_sticky, m_rxwm, m_txwm, m_txd;
  logic        m_txwe, m_irq;

  task automatic m_reset();
    m_ctrl = '0; m_baud = '0; m_inten = '0; m_sticky = '0;
    m_rxwm = 8'd1; m_txwm = 8'd0; m_txd = '0; m_txwe = 0; m_irq = 0;
  endtask

  function automatic logic m_pop();
    return bus_sel && bus_rd && bus_addr == 4'd0 && !rx_fifo_empty;
  endfunction

  function automatic logic [7:0] m_stat();
    logic [7:0] s;
    s = m_sticky;
    s[0] = int'(rx_level) >= int'(m_rxwm) % 32;
    s[1] = int'(tx_level) <= int'(m_txwm) % 32;
    return s;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [3:0] a);
    case (a)
      4'd0: return rx_fifo_empty ? 32'd0 : 32'(rx_data);
      4'd1: return {24'd0, m_txwe, m_pop(), rx_fifo_full, tx_fifo_full, rx_fifo_empty,
                    m_sticky[2], m_sticky[3], busy};
      4'd2: return 32'(m_ctrl);
      4'd3: return 32'(m_baud);
      4'd4: return 32'(m_inten);
      4'd5: return 32'(m_stat());
      4'd6: return {16'd0, m_txwm, m_rxwm};
      4'd7: return 32'(rx_level) * 65536 + 32'(tx_level);
      default: return 32'd0;
    endcase
  endfunction

  // Advance model and DUT one clock with the inputs currently driven
  task automatic clk_step();
    logic w, r;
    logic [3:0] a;
    logic [7:0] set, clr, ns, nst, ni, nrx, ntx, ntd;
    logic [5:0] nc;
    logic [15:0] nb;
    logic nwe, nirq;
    a = bus_addr; w = bus_sel & bus_wr; r = bus_sel & bus_rd;
    set = '0;
    set[2] = parity_err_p;
    set[3] = stop_err_p;
    set[4] = rx_push & rx_fifo_full;
    set[5] = w && a == 4'd0 && tx_fifo_full;
    set[6] = r && a == 4'd0 && rx_fifo_empty;
    clr = (w && a == 4'd5) ? bus_wdata[7:0] : 8'h00;
    ns  = ((m_sticky & ~clr) | set) & 8'hFC;
    nst = ns | (m_stat() & 8'h03);
    nirq = m_ctrl[0] && ((nst & m_inten) != 8'h00);
    nwe = w && a == 4'd0 && !tx_fifo_full;
    ntd = nwe ? bus_wdata[7:0] : m_txd;
    nc = m_ctrl;
    if (w && a == 4'd2) begin
      nc[0] = bus_wdata[0]; nc[4] = bus_wdata[4]; nc[5] = bus_wdata[5];
      if (!busy) nc[3:1] = bus_wdata[3:1];
    end
    nb  = (w && a == 4'd3 && !busy && !m_ctrl[0]) ? bus_wdata[15:0] : m_baud;
    ni  = (w && a == 4'd4) ? bus_wdata[7:0] : m_inten;
    nrx = (w && a == 4'd6) ? bus_wdata[7:0] : m_rxwm;
    ntx = (w && a == 4'd6) ? bus_wdata[15:8] : m_txwm;
    @(posedge clock); #1;
    m_sticky = ns; m_irq = nirq; m_txwe = nwe; m_txd = ntd; m_ctrl = nc;
    m_baud = nb; m_inten = ni; m_rxwm = nrx; m_txwm = ntx;
  endtask

  task automatic bus_idle();
    bus_sel = 0; bus_wr = 0; bus_rd = 0;
  endtask

  task automatic bus_set(input logic wr, input logic rd, input logic [3:0] a, input logic [31:0] d);
    bus_sel = 1; bus_wr = wr; bus_rd = rd; bus_addr = a; bus_wdata = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m_reset();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    for (int a = 0; a < 16; a++) begin
      bus_addr = 4'(a); #1;
      n_vec++;
      if (bus_rdata !== m_rdata(4'(a))) begin
        n_err++; $display("FAIL reset_read[%0d]: got %08h expected %08h", a, bus_rdata, m_rdata(4'(a)));
      end
    end
    bus_addr = 4'd6; #1;
    n_vec++;
    if (bus_rdata !== 32'h0000_0001) begin
      n_err++; $display("FAIL reset_wmark: got %08h expected 00000001", bus_rdata);
    end
    n_vec++;
    if ({irq, tx_fifo_wr_en, baud_rate} !== 18'd0) begin
      n_err++; $display("FAIL reset_outs: got irq=%0b wr_en=%0b baud=%04h expected 0/0/0000", irq, tx_fifo_wr_en, baud_rate);
    end
    @(posedge clock); #1;
    reset_n = 1;
  endtask

  task automatic test_tx_push();
    tx_fifo_full = 0;
    bus_set(1, 0, 4'd0, 32'h0000_01A5);
    clk_step();
    bus_idle();
    n_vec++;
    if (tx_fifo_wr_en !== 1'b1 || tx_fifo_data !== 8'hA5) begin
      n_err++; $display("FAIL tx_push: got en=%0b data=%02h expected 1/a5", tx_fifo_wr_en, tx_fifo_data);
    end
    clk_step();
    n_vec++;
    if (tx_fifo_wr_en !== 1'b0) begin
      n_err++; $display("FAIL tx_push_width: got en=%0b expected 0", tx_fifo_wr_en);
    end
    tx_fifo_full = 1;
    bus_set(1, 0, 4'd0, 32'h0000_005A);
    clk_step();
    bus_idle(); tx_fifo_full = 0;
    n_vec++;
    if (tx_fifo_wr_en !== 1'b0) begin
      n_err++; $display("FAIL tx_full_push: got en=%0b expected 0", tx_fifo_wr_en);
    end
    bus_addr = 4'd5; #1;
    n_vec++;
    if (bus_rdata[5] !== 1'b1 || bus_rdata !== m_rdata(4'd5)) begin
      n_err++; $display("FAIL tx_ovf_flag: got %08h expected %08h", bus_rdata, m_rdata(4'd5));
    end
  endtask

  task automatic test_rx_pop();
    rx_data = 8'h3C; rx_fifo_empty = 0;
    bus_set(0, 1, 4'd0, 32'd0); #1;
    n_vec++;
    if (bus_rdata !== 32'h3C || rx_fifo_rd_en !== 1'b1) begin
      n_err++; $display("FAIL rx_pop: got data=%08h en=%0b expected 0000003c/1", bus_rdata, rx_fifo_rd_en);
    end
    clk_step();
    bus_idle(); #1;
    n_vec++;
    if (rx_fifo_rd_en !== 1'b0) begin
      n_err++; $display("FAIL rx_pop_width: got en=%0b expected 0", rx_fifo_rd_en);
    end
    rx_fifo_empty = 1;
    bus_set(0, 1, 4'd0, 32'd0); #1;
    n_vec++;
    if (bus_rdata !== 32'd0 || rx_fifo_rd_en !== 1'b0) begin
      n_err++; $display("FAIL rx_empty_read: got data=%08h en=%0b expected 0/0", bus_rdata, rx_fifo_rd_en);
    end
    clk_step();
    bus_idle(); rx_fifo_empty = 0;
    bus_addr = 4'd5; #1;
    n_vec++;
    if (bus_rdata[6] !== 1'b1 || bus_rdata !== m_rdata(4'd5)) begin
      n_err++; $display("FAIL rx_udf_flag: got %08h expected %08h", bus_rdata, m_rdata(4'd5));
    end
  endtask

  task automatic test_irq();
    bus_set(1, 0, 4'd5, 32'hFF); clk_step();
    bus_set(1, 0, 4'd4, 32'h04); clk_step();
    bus_set(1, 0, 4'd2, 32'h01); clk_step();
    bus_idle();
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL irq_quiet: got %0b expected 0", irq);
    end
    parity_err_p = 1; clk_step(); parity_err_p = 0;
    n_vec++;
    if (irq !== 1'b1 || irq !== m_irq) begin
      n_err++; $display("FAIL irq_rise: got %0b expected 1", irq);
    end
    parity_err_p = 1; bus_set(1, 0, 4'd5, 32'h04); clk_step();
    parity_err_p = 0; bus_idle(); bus_addr = 4'd5; #1;
    n_vec++;
    if (bus_rdata[2] !== 1'b1 || irq !== 1'b1) begin
      n_err++; $display("FAIL set_beats_w1c: got stat=%08h irq=%0b expected bit2=1 irq=1", bus_rdata, irq);
    end
    bus_set(1, 0, 4'd5, 32'h04); #1;
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL irq_hold: got %0b expected 1", irq);
    end
    clk_step(); bus_idle();
    n_vec++;
    if (irq !== 1'b0 || irq !== m_irq) begin
      n_err++; $display("FAIL irq_fall: got %0b expected 0", irq);
    end
  endtask

  task automatic test_busy();
    busy = 1;
    bus_set(1, 0, 4'd2, 32'h3F); clk_step();
    bus_idle(); bus_addr = 4'd2; #1;
    n_vec++;
    if (bus_rdata !== 32'h31) begin
      n_err++; $display("FAIL ctrl_busy: got %08h expected 00000031", bus_rdata);
    end
    bus_set(1, 0, 4'd3, 32'h0100); clk_step(); bus_idle();
    n_vec++;
    if (baud_rate !== 16'h0000) begin
      n_err++; $display("FAIL baud_locked: got %04h expected 0000", baud_rate);
    end
    busy = 0;
    bus_set(1, 0, 4'd2, 32'h00); clk_step();
    bus_set(1, 0, 4'd3, 32'h0100); clk_step(); bus_idle();
    n_vec++;
    if (baud_rate !== 16'h0100 || baud_rate !== m_baud) begin
      n_err++; $display("FAIL baud_write: got %04h expected 0100", baud_rate);
    end
  endtask

  task automatic test_reset_mid_access();
    tx_fifo_full = 0; rx_fifo_empty = 0;
    bus_set(1, 0, 4'd0, 32'h77); clk_step();
    n_vec++;
    if (tx_fifo_wr_en !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_push: got %0b expected 1", tx_fifo_wr_en);
    end
    bus_rd = 1;
    #2 reset_n = 0;
    #1;
    n_vec++;
    if (tx_fifo_wr_en !== 1'b0 || rx_fifo_rd_en !== 1'b0 || irq !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes: got wr=%0b rd=%0b irq=%0b expected 0/0/0", tx_fifo_wr_en, rx_fifo_rd_en, irq);
    end
    bus_idle(); m_reset();
    @(posedge clock); #1;
    reset_n = 1;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      n_vec++;
      if (tx_fifo_wr_en !== 1'b0 || rx_fifo_rd_en !== 1'b0) begin
        n_err++; $display("FAIL post_reset_strobe[%0d]: got wr=%0b rd=%0b expected 0/0", i, tx_fifo_wr_en, rx_fifo_rd_en);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus_sel   = $urandom_range(0, 3) != 0;
      bus_wr    = 1'($urandom_range(0, 1));
      bus_rd    = 1'($urandom_range(0, 1));
      bus_addr  = 4'($urandom_range(0, 9));
      bus_wdata = $urandom;
      tx_fifo_full  = $urandom_range(0, 3) == 0;
      rx_fifo_full  = $urandom_range(0, 3) == 0;
      rx_fifo_empty = $urandom_range(0, 3) == 0;
      busy          = $urandom_range(0, 3) == 0;
      tx_level  = 5'($urandom_range(0, 16));
      rx_level  = 5'($urandom_range(0, 16));
      rx_data   = 8'($urandom);
      rx_push      = $urandom_range(0, 3) == 0;
      parity_err_p = $urandom_range(0, 7) == 0;
      stop_err_p   = $urandom_range(0, 7) == 0;
      #1;
      n_vec++;
      if (bus_rdata !== m_rdata(bus_addr) || rx_fifo_rd_en !== m_pop()) begin
        n_err++; $display("FAIL rnd_read[%0d] addr=%0d: got %08h/%0b expected %08h/%0b",
                          i, bus_addr, bus_rdata, rx_fifo_rd_en, m_rdata(bus_addr), m_pop());
      end
      clk_step();
      n_vec++;
      if (tx_fifo_wr_en !== m_txwe || tx_fifo_data !== m_txd || irq !== m_irq ||
          {rx_en, tx_en, parity_enable, parity, stop_bit, uart_en} !== m_ctrl || baud_rate !== m_baud) begin
        n_err++; $display("FAIL rnd_regs[%0d]: got we=%0b d=%02h irq=%0b ctrl=%02h baud=%04h expected %0b/%02h/%0b/%02h/%04h",
                          i, tx_fifo_wr_en, tx_fifo_data, irq,
                          {rx_en, tx_en, parity_enable, parity, stop_bit, uart_en}, baud_rate,
                          m_txwe, m_txd, m_irq, m_ctrl, m_baud);
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_tx_push();
    test_rx_pop();
    test_irq();
    test_busy();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_csr_bank.md
Name: uart_csr_bank

Overview:
Parametrised second-generation UART register bank between the processor load/store path and the UART core (tx/rx FIFOs, shifter, baud generator).
- Adds over the first generation: generic character width and FIFO depth, FIFO level and watermark registers, sticky write-1-to-clear error flags, interrupt enable/status with a registered irq, and single-cycle pop/push strobes qualified by explicit bus read/write strobes.

Parameters:
DATA_BITS, 8, character width (5..9)
BAUD_W, 16, baud divisor width
FIFO_DEPTH, 16, depth of both UART FIFOs (power of 2)
LEVEL_W, $clog2(FIFO_DEPTH)+1, FIFO level width
BAUD_RESET, 16'd0, baud register reset value

Ports:
clock  in  1  system clock, posedge
reset_n  in  1  asynchronous active-low reset
bus_sel  in  1  UART address window selected
bus_wr  in  1  write strobe, one cycle per access
bus_rd  in  1  read strobe, one cycle per access
bus_addr  in  4  word index
bus_wdata  in  32  write data
bus_rdata  out  32  read data, combinational from bus_addr
irq  out  1  interrupt, registered
tx_fifo_full, rx_fifo_full, rx_fifo_empty, busy  in  1 each  core status
tx_level, rx_level  in  LEVEL_W each  FIFO occupancy
rx_data  in  DATA_BITS  rx FIFO head
rx_push  in  1  core pushes an rx character this cycle
parity_err_p, stop_err_p  in  1 each  single-cycle error pulses from receiver
tx_fifo_wr_en  out  1  push strobe
tx_fifo_data  out  DATA_BITS  push data
rx_fifo_rd_en  out  1  pop strobe
uart_en, stop_bit, parity, parity_enable, tx_en, rx_en  out  1 each  CTRL fields
baud_rate  out  BAUD_W  baud divisor

Behaviour:
- Map (word index):
  - 0 DATA: W push / R pop
  - 1 STATUS: RO live
  - 2 CTRL
  - 3 BAUD
  - 4 INT_EN
  - 5 INT_STAT: W1C
  - 6 WMARK: rx_wm[7:0], tx_wm[15:8]
  - 7 LEVEL: RO, {rx_level @[23:16], tx_level @[7:0]}
  - 8 TIMEOUT, optional feature only
  - Others: read 0, writes ignored
- Reset: all registers 0 except BAUD=BAUD_RESET, WMARK rx_wm=1 / tx_wm=0. Outputs irq, tx_fifo_wr_en, rx_fifo_rd_en = 0.
- Access qualification: wr = bus_sel&bus_wr; rd = bus_sel&bus_rd.
- DATA write:
  - If !tx_fifo_full: tx_fifo_data <= wdata[DATA_BITS-1:0] and tx_fifo_wr_en = 1 for exactly the next cycle.
  - If full: no push, set TX_OVF.
- DATA read: bus_rdata = zero-extended rx_data.
  - If !rx_fifo_empty: rx_fifo_rd_en pulses combinationally in the same cycle as rd.
  - If empty: no pop, rdata = 0, set RX_UDF.
  - rx_fifo_rd_en is never asserted without rd.
- CTRL [5:0] = rx_en, tx_en, parity_enable, parity, stop_bit, uart_en.
  - Bits 3:1 are write-ignored while busy; bits 0, 4, 5 are always writable.
- BAUD: write ignored while busy | uart_en.
- STATUS [7:0] = tx_wr_en, rx_rd_en, rx_full, tx_full, rx_empty, parity_err_sticky, stop_err_sticky, busy. Sampled live.
- INT_STAT bits:
  - 0 RX_WM = rx_level >= rx_wm (level, not sticky)
  - 1 TX_WM = tx_level <= tx_wm (level, not sticky)
  - 2 PAR_ERR, sticky
  - 3 STOP_ERR, sticky
  - 4 RX_OVR (rx_push while rx_fifo_full), sticky
  - 5 TX_OVF, sticky
  - 6 RX_UDF, sticky
  - 7 RX_TMO, sticky
- Sticky bits clear on W1C. A set event in the same cycle as W1C wins, so the bit stays 1. Writes to bits 0/1 have no effect.
- irq <= uart_en & |(INT_STAT & INT_EN[7:0]); one cycle latency from the event.
- Watermark compare is unsigned, using the low LEVEL_W bits of each wm field. rx_wm = 0 makes RX_WM always true.
- reset_n assertion mid-access clears pending strobes immediately; no push/pop issues after reset release without a new access.

Optional Feature:
UART_RX_TIMEOUT_EN:
- With the macro: TIMEOUT register (16 bits, reset 0) and a 16-bit idle counter.
  - Counter resets on rx_push, on an rx pop, or while rx_fifo_empty.
  - Otherwise increments while uart_en & rx_en.
  - When it equals TIMEOUT (TIMEOUT != 0), RX_TMO sets and the counter holds until reset.
- Without the macro: index 8 reads 0 and RX_TMO is constant 0.

Decomposition:
- Package uart_pkg: register index constants (DATA_REG..TIMEOUT_REG), INT_STAT bit-position enum, CTRL field positions, packed struct for CTRL.
- Sub-module uart_sticky_flags: vector of set/W1C sticky bits with set-priority, width parameter; instantiated for bits 2..7.

Test Plan:
- Reset, then read all indices -> BAUD=BAUD_RESET, WMARK=0x0001, all others 0; irq=0.
- Write DATA 0x1A5 with tx_fifo_full=0 -> tx_fifo_data=0xA5, tx_fifo_wr_en high for exactly 1 cycle. Repeat with full=1 -> no strobe, INT_STAT[5]=1.
- Read DATA with rx_data=0x3C, empty=0 -> rdata=0x3C, one rd_en pulse. Read again with empty=1 -> rdata=0, INT_STAT[6]=1.
- INT_EN=0x04, uart_en=1, parity_err_p pulse -> irq=1 next cycle. W1C 0x04 in the same cycle as a second pulse -> bit stays 1. Later W1C -> irq falls 1 cycle after.
- busy=1: write CTRL 0x3F -> reads 0x31. Write BAUD 0x0100 -> unchanged. busy=0, uart_en=0: BAUD write takes.
- (UART_RX_TIMEOUT_EN) TIMEOUT=10, one rx_push, no pops -> RX_TMO sets on the 10th idle cycle. Pop before then -> no set.
